// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch front end.
// Instruction width, PC step and the fetch queue entry layout.
package riscv_pkg;
  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] data;
    logic               err;
    logic               filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential request issue, in-order
// response buffering and redirect flush with stale-response dropping.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [XLEN-1:0]    imem_req_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  input  logic               imem_rsp_err_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [INSTR_W-1:0] inst_o,
  output logic [XLEN-1:0]    inst_pc_o,
  output logic               inst_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    fetch_pc;
  logic               run;
  logic [XLEN-1:0]    pc_q   [DEPTH];
  logic [INSTR_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]   err_q;
  logic [DEPTH-1:0]   filled_q;
  logic [PW-1:0]      alloc_ptr;
  logic [PW-1:0]      fill_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      drop_cnt;
  // allocated but not yet filled; disambiguates alloc_ptr == fill_ptr
  logic [CW-1:0]      pend_cnt;

  logic credit;
  logic issue;
  logic rsp_drop;
  logic rsp_fill;
  logic rsp_fire;
  logic consume;

  assign credit = ((CW+1)'(count) + (CW+1)'(drop_cnt))
                < (CW+1)'(DEPTH);
  assign imem_req_valid_o = run & credit;
  assign imem_req_addr_o  = run ? fetch_pc : '0;
  assign issue    = imem_req_valid_o & imem_req_ready_i;
  assign rsp_drop = imem_rsp_valid_i & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid_i & (drop_cnt == '0)
                  & (pend_cnt != '0);
  assign rsp_fire = rsp_drop | rsp_fill;

  assign inst_valid_o = (count != '0) & filled_q[rd_ptr];
  assign inst_o       = data_q[rd_ptr];
  assign inst_pc_o    = pc_q[rd_ptr];
  assign inst_err_o   = err_q[rd_ptr];
  assign consume      = inst_valid_o & inst_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      run       <= 1'b0;
      err_q     <= '0;
      filled_q  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      pend_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (redirect_valid_i) begin
        fetch_pc  <= redirect_pc_i & ~XLEN'(3);
        filled_q  <= '0;
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        pend_cnt  <= '0;
        drop_cnt  <= drop_cnt + pend_cnt
                   + CW'(issue) - CW'(rsp_fire);
      end else begin
        if (issue) begin
          pc_q[alloc_ptr]     <= fetch_pc;
          filled_q[alloc_ptr] <= 1'b0;
          alloc_ptr           <= alloc_ptr + 1'b1;
          fetch_pc            <= fetch_pc + XLEN'(PC_STEP);
        end
        if (rsp_fill) begin
          data_q[fill_ptr]   <= imem_rsp_data_i;
          err_q[fill_ptr]    <= imem_rsp_err_i;
          filled_q[fill_ptr] <= 1'b1;
          fill_ptr           <= fill_ptr + 1'b1;
        end
        if (consume) begin
          filled_q[rd_ptr] <= 1'b0;
          rd_ptr           <= rd_ptr + 1'b1;
        end
        count    <= count + CW'(issue) - CW'(consume);
        pend_cnt <= pend_cnt + CW'(issue) - CW'(rsp_fill);
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end, the successor of the fixed single-PC fetch stage. It generates sequential fetch addresses and issues them over a valid/ready request channel to an instruction memory with variable, in-order response latency. Returned instructions are buffered with their PCs in a DEPTH-entry queue and presented to decode over a valid/ready channel. A redirect (branch/jump) flushes the queue and discards responses still in flight for stale requests.

## Interface
- XLEN, 64, address/PC width
- RESET_PC, 64'h0, first fetch address after reset (XLEN bits, bits [1:0] must be 0)
- DEPTH, 4, queue entries and bound on outstanding requests; power of two, >= 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
- imem_req_valid_o  out  1  request pending
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  request address
- imem_rsp_valid_i  in  1  response beat, in request order
- imem_rsp_data_i  in  32  instruction word
- imem_rsp_err_i  in  1  access fault for this response
- inst_valid_o  out  1  head entry holds a returned instruction
- inst_ready_i  in  1  decode consumes head
- inst_o  out  32  head instruction
- inst_pc_o  out  XLEN  head PC
- inst_err_o  out  1  head access-fault flag

## Operation
- State: fetch_pc; run flag; entry array {pc, data, err, filled}; alloc/fill/read pointers (log2 DEPTH bits, wrap modulo DEPTH); count (0..DEPTH); drop_cnt (0..DEPTH).
- Reset: fetch_pc = RESET_PC, pointers, count, drop_cnt, all filled bits and run = 0. All outputs 0 while rst is high.
- run sets on the first clock edge after rst deasserts; imem_req_valid_o = run & (count + drop_cnt < DEPTH).
- imem_req_addr_o = fetch_pc.
- Issue fire (req valid & ready): entry[alloc].pc = fetch_pc, filled = 0; alloc++; count++; fetch_pc += 4 (wraps modulo 2^XLEN).
- Response fire: if drop_cnt > 0, discard and decrement drop_cnt. Otherwise write data/err into entry[fill], set filled, fill++. A response with nothing outstanding is a protocol violation: ignore it, no state change.
- inst_valid_o = count > 0 & entry[read].filled. inst_o, inst_pc_o and inst_err_o are driven from entry[read].
- Consume fire (valid & ready): clear filled, read++, count--.
- Redirect, highest priority:
  - fetch_pc = redirect_pc_i & ~3.
  - Queue emptied: count = 0, all pointers equal, filled cleared.
  - drop_cnt_next = drop_cnt + (allocated-but-unfilled entries) + issue_fire − rsp_fire.
  - A request accepted in the redirect cycle carries the old address and is counted as stale.
  - A consume handshake in the redirect cycle completes; discarding it is decode's responsibility.
- Simultaneous issue, response and consume in one cycle all take effect. Count changes by issue − consume.
- An error response is queued like any other. fetch_queue never stops on an error; decode handles the fault.

## Timing
- Request fires in cycle N.
- Earliest response is cycle N+1, written at the N+1 edge.
- inst_valid_o rises in cycle N+2. There is no response-to-output bypass.
- An entry is occupied from issue until consume, which is at least 3 cycles. With 1-cycle memory and inst_ready_i held at 1, DEPTH >= 3 sustains 1 instruction/cycle. DEPTH = 2 gives 2 instructions per 3 cycles.
- Redirect in cycle R: the first new-PC request is visible in cycle R+1 if credit allows.
- After R, inst_valid_o stays low until the first post-redirect response is filled.
- Output backpressure: when count + drop_cnt = DEPTH, imem_req_valid_o drops in the same cycle, derived from registers. There is no combinational path from inst_ready_i or redirect_valid_i to any output.
- Outputs are stable while valid and not ready. Requests are never retracted, except that the address changes after a redirect.

## Structure
- riscv_pkg holds:
  - XLEN
  - INSTR_W = 32
  - fetch_entry_t packed struct {pc, data, err, filled}
  - the constant PC_STEP = 4
- A single module; the entry array and pointer logic are small enough that no sub-module is warranted.
- fetch_queue replaces the fetch stage instance in core_top. Its redirect inputs take the current branch target/taken nets.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC = 0x1000, 1-cycle memory, inst_ready_i = 1.
  - Required: requests at 0x1000, 0x1004, 0x1008…; first inst_valid_o two cycles after the first fire; one instruction per cycle; PCs matching.
- Backpressure:
  - Stimulus: inst_ready_i = 0, DEPTH = 4.
  - Required: exactly 4 requests issued, then imem_req_valid_o = 0. Raising inst_ready_i drains 0x1000..0x100C in order.
- Redirect with in-flight requests:
  - Stimulus: 3-cycle memory, 3 requests outstanding, redirect_pc_i = 0x2002.
  - Required: next request at 0x2000; 3 stale responses discarded; first instruction delivered has PC 0x2000.
- Redirect coincident with issue fire and response fire:
  - Required: drop_cnt accounting correct; no stale instruction ever reaches inst_valid_o.
- Error propagation:
  - Stimulus: imem_rsp_err_i = 1 on the 2nd response.
  - Required: the 2nd instruction carries inst_err_o = 1 and neighbours 0; fetch continues.
- Mid-operation reset:
  - Stimulus: assert rst with a full queue and 2 outstanding requests.
  - Required: all outputs 0 immediately; after release, fetch restarts at RESET_PC with no stale output.
